// File: rtl/zeroheti_pkg.sv
// Shared types and configuration for the zeroheti interrupt-accept slice.
// Holds the core configuration record, the accept FSM state encoding and
// the latched request record used by zeroheti_irq_accept.
package zeroheti_pkg;

   typedef struct packed {
      int unsigned nr_irqs;
      int unsigned nr_prio;
      int unsigned nest_depth;
      int unsigned addr_width;
   } core_cfg_t;

   localparam core_cfg_t CoreCfg = '{
      nr_irqs:    64,
      nr_prio:    8,
      nest_depth: 4,
      addr_width: 32
   };

   localparam int unsigned IrqWidth   = $clog2(CoreCfg.nr_irqs);
   localparam int unsigned PrioWidth  = $clog2(CoreCfg.nr_prio);
   localparam int unsigned DepthWidth = $clog2(CoreCfg.nest_depth + 1);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      ACK
   } accept_state_e;

   // Request as captured from the controller while a trap is pending.
   typedef struct packed {
      logic [IrqWidth-1:0]  id;
      logic [PrioWidth-1:0] level;
      logic                 shv;
   } irq_req_t;

endpackage

// File: rtl/zeroheti_level_stack.sv
// LIFO of preempted interrupt levels. A push stores the level that was
// active before a nested take; a pop returns it on mret. Push has priority
// if both are requested; the caller never asks for both at once.
module zeroheti_level_stack #(
   parameter int unsigned Width      = 3,
   parameter int unsigned Depth      = 4,
   parameter int unsigned DepthWidth = $clog2(Depth + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic                  pop,
   input  logic [Width-1:0]      data,
   output logic [Width-1:0]      top,
   output logic [DepthWidth-1:0] depth,
   output logic                  full,
   output logic                  empty
);

   localparam int unsigned IdxWidth = (Depth > 1) ? $clog2(Depth) : 1;

   logic [Width-1:0]      mem [Depth];
   logic [DepthWidth-1:0] count;
   logic [IdxWidth-1:0]   top_idx;

   assign full    = (count == DepthWidth'(Depth));
   assign empty   = (count == '0);
   assign depth   = count;
   assign top_idx = IdxWidth'(count - 1'b1);
   assign top     = mem[top_idx];

   // Occupancy counter; the only state that needs a defined reset value.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (push && !full) begin
         count <= count + 1'b1;
      end else if (pop && !empty) begin
         count <= count - 1'b1;
      end
   end

   // Entry storage written on push.
   // NOTE: the entries are deliberately not reset; an entry is only read
   // after it was pushed, so resetting them would add logic for nothing.
   always_ff @(posedge clk) begin
      if (!rst && push && !full) begin
         mem[IdxWidth'(count)] <= data;
      end
   end

endmodule

// File: rtl/zeroheti_irq_accept.sv
// Core-side interrupt acceptance: gates controller requests against MIE and
// the current preemption level, raises a trap request, acknowledges the
// controller for one cycle and tracks nested levels for mret.
// Optional macro ZEROHETI_IRQ_ACCEPT_SHV_EN enables selective hardware
// vectoring through mtvt_i; without it every trap goes to mtvec_i.
module zeroheti_irq_accept
   import zeroheti_pkg::*;
#(
   parameter int unsigned NrIrqs    = CoreCfg.nr_irqs,
   parameter int unsigned NrPrio    = CoreCfg.nr_prio,
   parameter int unsigned NestDepth = CoreCfg.nest_depth,
   parameter int unsigned AddrWidth = CoreCfg.addr_width,
   parameter int unsigned IrqW      = $clog2(NrIrqs),
   parameter int unsigned PrioW     = $clog2(NrPrio),
   parameter int unsigned DepthW    = $clog2(NestDepth + 1)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 irq_valid_i,
   input  logic [IrqW-1:0]      irq_id_i,
   input  logic [PrioW-1:0]     irq_level_i,
   input  logic [1:0]           irq_priv_i,
   input  logic                 irq_shv_i,
   input  logic                 irq_nest_i,
   output logic [IrqW-1:0]      irq_id_o,
   output logic                 irq_ack_o,
   input  logic                 mie_i,
   input  logic [AddrWidth-1:0] mtvec_i,
   input  logic [AddrWidth-1:0] mtvt_i,
   output logic                 trap_req_o,
   input  logic                 trap_ready_i,
   output logic [AddrWidth-1:0] trap_vec_o,
   output logic [IrqW-1:0]      trap_id_o,
   input  logic                 mret_i,
   output logic [PrioW-1:0]     cur_level_o,
   output logic [DepthW-1:0]    depth_o,
   output logic                 err_o
);

   accept_state_e        state;
   irq_req_t             req_q;
   irq_req_t             incoming;
   logic [PrioW-1:0]     cur_level;
   logic [PrioW-1:0]     stack_top;
   logic [DepthW-1:0]    depth;
   logic                 full;
   logic                 empty;
   logic                 eligible;
   logic                 take;
   logic                 pop;
   logic                 shv_in;
   logic [AddrWidth-1:0] base_vec;
   logic [AddrWidth-1:0] vec;

`ifdef ZEROHETI_IRQ_ACCEPT_SHV_EN
   assign shv_in = irq_shv_i;
   assign vec    = req_q.shv ? (mtvt_i + (AddrWidth'(req_q.id) << 2)) : base_vec;
   logic unused_bits;
   assign unused_bits = ^mtvec_i[1:0];
`else
   assign shv_in = 1'b0;
   assign vec    = base_vec;
   logic unused_bits;
   assign unused_bits = ^{mtvt_i, irq_shv_i, mtvec_i[1:0], req_q.shv};
`endif

   assign base_vec = {mtvec_i[AddrWidth-1:2], 2'b00};
   assign incoming = '{id: irq_id_i, level: irq_level_i, shv: shv_in};

   assign eligible = irq_valid_i && mie_i && (irq_priv_i == 2'b11)
                     && (irq_level_i > cur_level)
                     && (empty || irq_nest_i) && !full;

   // A take pushes; an mret colliding with a take is dropped and flagged.
   assign take = (state == REQ) && eligible && trap_ready_i;
   assign pop  = mret_i && !empty && !take;

   zeroheti_level_stack #(
      .Width (PrioW),
      .Depth (NestDepth),
      .DepthWidth (DepthW)
   ) u_stack (
      .clk   (clk_i),
      .rst   (rst_i),
      .push  (take),
      .pop   (pop),
      .data  (cur_level),
      .top   (stack_top),
      .depth (depth),
      .full  (full),
      .empty (empty)
   );

   // Accept FSM with registered handshake outputs, level and error tracking.
   // NOTE: all state here uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= IDLE;
         req_q      <= '0;
         trap_req_o <= 1'b0;
         irq_ack_o  <= 1'b0;
         irq_id_o   <= '0;
         cur_level  <= '0;
         err_o      <= 1'b0;
      end else begin
         irq_ack_o <= 1'b0;
         irq_id_o  <= '0;
         case (state)
            IDLE: begin
               if (eligible) begin
                  state      <= REQ;
                  req_q      <= incoming;
                  trap_req_o <= 1'b1;
               end
            end
            REQ: begin
               if (!eligible) begin
                  state      <= IDLE;
                  trap_req_o <= 1'b0;
               end else if (trap_ready_i) begin
                  state      <= ACK;
                  trap_req_o <= 1'b0;
                  irq_ack_o  <= 1'b1;
                  irq_id_o   <= req_q.id;
               end else if (irq_level_i > req_q.level) begin
                  req_q <= incoming;
               end
            end
            ACK: begin
               state <= IDLE;
            end
            default: begin
               state      <= IDLE;
               trap_req_o <= 1'b0;
            end
         endcase

         if (take) begin
            cur_level <= req_q.level;
         end else if (pop) begin
            cur_level <= stack_top;
         end

         if (mret_i && (empty || take)) begin
            err_o <= 1'b1;
         end
      end
   end

   assign trap_id_o   = req_q.id;
   assign trap_vec_o  = trap_req_o ? vec : '0;
   assign cur_level_o = cur_level;
   assign depth_o     = depth;

endmodule

// File: tb/tb_zeroheti_irq_accept.sv
// Directed bench for zeroheti_irq_accept: take, threshold, withdraw,
// re-latch, stack bounds, reset abort, vectoring and mret collision.
module tb_zeroheti_irq_accept;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        irq_valid_i;
   logic [5:0]  irq_id_i;
   logic [2:0]  irq_level_i;
   logic [1:0]  irq_priv_i;
   logic        irq_shv_i;
   logic        irq_nest_i;
   logic [5:0]  irq_id_o;
   logic        irq_ack_o;
   logic        mie_i;
   logic [31:0] mtvec_i;
   logic [31:0] mtvt_i;
   logic        trap_req_o;
   logic        trap_ready_i;
   logic [31:0] trap_vec_o;
   logic [5:0]  trap_id_o;
   logic        mret_i;
   logic [2:0]  cur_level_o;
   logic [2:0]  depth_o;
   logic        err_o;

   int total = 0;
   int bad   = 0;

   zeroheti_irq_accept dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .irq_valid_i  (irq_valid_i),
      .irq_id_i     (irq_id_i),
      .irq_level_i  (irq_level_i),
      .irq_priv_i   (irq_priv_i),
      .irq_shv_i    (irq_shv_i),
      .irq_nest_i   (irq_nest_i),
      .irq_id_o     (irq_id_o),
      .irq_ack_o    (irq_ack_o),
      .mie_i        (mie_i),
      .mtvec_i      (mtvec_i),
      .mtvt_i       (mtvt_i),
      .trap_req_o   (trap_req_o),
      .trap_ready_i (trap_ready_i),
      .trap_vec_o   (trap_vec_o),
      .trap_id_o    (trap_id_o),
      .mret_i       (mret_i),
      .cur_level_o  (cur_level_o),
      .depth_o      (depth_o),
      .err_o        (err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock and settle past the edge before sampling.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic request(input logic [5:0] id, input logic [2:0] lvl, input logic nest);
      irq_valid_i = 1'b1;
      irq_id_i    = id;
      irq_level_i = lvl;
      irq_nest_i  = nest;
   endtask

   initial begin
      rst_i        = 1'b1;
      irq_valid_i  = 1'b0;
      irq_id_i     = '0;
      irq_level_i  = '0;
      irq_priv_i   = 2'b11;
      irq_shv_i    = 1'b0;
      irq_nest_i   = 1'b0;
      mie_i        = 1'b1;
      mtvec_i      = 32'h0000_2003;
      mtvt_i       = 32'h0000_1000;
      trap_ready_i = 1'b0;
      mret_i       = 1'b0;
      tick();
      tick();
      rst_i = 1'b0;

      // Reset state
      check("rst_trap_req", trap_req_o, 0);
      check("rst_ack", irq_ack_o, 0);
      check("rst_irq_id", irq_id_o, 0);
      check("rst_vec", trap_vec_o, 0);
      check("rst_level", cur_level_o, 0);
      check("rst_depth", depth_o, 0);
      check("rst_err", err_o, 0);

      // Basic take
      request(6'd5, 3'd3, 1'b0);
      tick();
      check("basic_req", trap_req_o, 1);
      check("basic_trap_id", trap_id_o, 5);
      check("basic_vec", trap_vec_o, 32'h0000_2000);
      tick();
      check("basic_req_hold", trap_req_o, 1);
      check("basic_no_early_ack", irq_ack_o, 0);
      trap_ready_i = 1'b1;
      tick();
      check("basic_ack", irq_ack_o, 1);
      check("basic_ack_id", irq_id_o, 5);
      check("basic_req_drop", trap_req_o, 0);
      check("basic_level", cur_level_o, 3);
      check("basic_depth", depth_o, 1);
      trap_ready_i = 1'b0;
      irq_valid_i  = 1'b0;
      tick();
      check("basic_ack_one_cycle", irq_ack_o, 0);
      check("basic_id_idle", irq_id_o, 0);

      // Threshold: equal level blocked, higher level nests
      request(6'd6, 3'd3, 1'b1);
      tick();
      check("thr_equal_blocked0", trap_req_o, 0);
      tick();
      check("thr_equal_blocked1", trap_req_o, 0);
      request(6'd8, 3'd4, 1'b1);
      tick();
      check("thr_higher_req", trap_req_o, 1);
      trap_ready_i = 1'b1;
      tick();
      check("thr_ack_id", irq_id_o, 8);
      check("thr_level", cur_level_o, 4);
      check("thr_depth", depth_o, 2);
      trap_ready_i = 1'b0;
      irq_valid_i  = 1'b0;
      tick();
      mret_i = 1'b1;
      tick();
      check("thr_mret1_level", cur_level_o, 3);
      check("thr_mret1_depth", depth_o, 1);
      tick();
      mret_i = 1'b0;
      check("thr_mret2_level", cur_level_o, 0);
      check("thr_mret2_depth", depth_o, 0);
      check("thr_err_clear", err_o, 0);

      // Withdraw before ready
      request(6'd7, 3'd2, 1'b0);
      tick();
      check("wd_req", trap_req_o, 1);
      check("wd_trap_id", trap_id_o, 7);
      irq_valid_i = 1'b0;
      tick();
      check("wd_req_drop", trap_req_o, 0);
      check("wd_no_ack", irq_ack_o, 0);
      tick();
      check("wd_no_ack_late", irq_ack_o, 0);
      check("wd_depth", depth_o, 0);
      check("wd_level", cur_level_o, 0);

      // Re-latch to a higher request while pending
      request(6'd9, 3'd2, 1'b0);
      tick();
      check("rl_first_id", trap_id_o, 9);
      request(6'd12, 3'd5, 1'b0);
      tick();
      check("rl_new_id", trap_id_o, 12);
      check("rl_req", trap_req_o, 1);
      trap_ready_i = 1'b1;
      tick();
      check("rl_ack", irq_ack_o, 1);
      check("rl_ack_id", irq_id_o, 12);
      check("rl_level", cur_level_o, 5);
      trap_ready_i = 1'b0;
      irq_valid_i  = 1'b0;
      tick();
      mret_i = 1'b1;
      tick();
      mret_i = 1'b0;
      check("rl_mret_level", cur_level_o, 0);
      check("rl_mret_depth", depth_o, 0);

      // Stack bounds: fill to four levels
      for (int lvl = 1; lvl <= 4; lvl++) begin
         request(6'(20 + lvl), 3'(lvl), 1'b1);
         trap_ready_i = 1'b1;
         tick();
         tick();
         check("fill_ack", irq_ack_o, 1);
         check("fill_ack_id", irq_id_o, 32'(20 + lvl));
         irq_valid_i  = 1'b0;
         trap_ready_i = 1'b0;
         tick();
      end
      check("full_depth", depth_o, 4);
      check("full_level", cur_level_o, 4);
      request(6'd30, 3'd6, 1'b1);
      tick();
      check("full_blocked0", trap_req_o, 0);
      tick();
      check("full_blocked1", trap_req_o, 0);
      irq_valid_i = 1'b0;
      mret_i = 1'b1;
      for (int n = 1; n <= 4; n++) begin
         tick();
         check("pop_depth", depth_o, 32'(4 - n));
         check("pop_level", cur_level_o, 32'(4 - n));
         check("pop_err", err_o, 0);
      end
      tick();
      mret_i = 1'b0;
      check("under_depth", depth_o, 0);
      check("under_level", cur_level_o, 0);
      check("under_err", err_o, 1);
      tick();
      check("err_sticky", err_o, 1);

      // Reset mid-request aborts with no ack and clears err
      request(6'd3, 3'd1, 1'b0);
      tick();
      check("abort_req", trap_req_o, 1);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      irq_valid_i = 1'b0;
      check("abort_req_drop", trap_req_o, 0);
      check("abort_no_ack", irq_ack_o, 0);
      check("abort_err_clear", err_o, 0);
      tick();
      check("abort_no_ack_late", irq_ack_o, 0);

      // Vector selection
      irq_shv_i = 1'b1;
      request(6'd10, 3'd1, 1'b0);
      tick();
`ifdef ZEROHETI_IRQ_ACCEPT_SHV_EN
      check("shv_vec", trap_vec_o, 32'h0000_1028);
`else
      check("shv_ignored_vec", trap_vec_o, 32'h0000_2000);
`endif
      irq_valid_i = 1'b0;
      tick();
      irq_shv_i = 1'b0;
      request(6'd10, 3'd1, 1'b0);
      tick();
      check("noshv_vec", trap_vec_o, 32'h0000_2000);

      // mret colliding with a take: push wins, pop dropped, err set
      trap_ready_i = 1'b1;
      mret_i       = 1'b1;
      tick();
      trap_ready_i = 1'b0;
      mret_i       = 1'b0;
      irq_valid_i  = 1'b0;
      check("coll_ack", irq_ack_o, 1);
      check("coll_depth", depth_o, 1);
      check("coll_level", cur_level_o, 1);
      check("coll_err", err_o, 1);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
